// File: rtl/spi_regif_pkg.sv
// Shared types and helpers for the burst SPI register interface.
// Holds the frame FSM encoding, the R/W bit encoding and the SPI mode decode.
package spi_regif_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_WAIT_CS
    } state_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    // Modes 0 and 3 sample on the rising SPI clock edge, modes 1 and 2 on the falling one.
    function automatic logic sample_on_rise(input int cpol, input int cpha);
        return (cpol == cpha);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Brings the asynchronous SPI pins into the clk domain and turns SPI clock and
// chip-select transitions into one-clk enables, three clks after the pin moves.
module spi_edge_sync
    import spi_regif_pkg::*;
#(
    parameter int CPOL = 0,
    parameter int CPHA = 0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic spi_cs_n,
    input  logic spi_clk,
    input  logic spi_mosi,
    output logic sample_en,
    output logic shift_en,
    output logic cs_fall,
    output logic cs_rise,
    output logic cs_n_lvl,
    output logic mosi_lvl
);

    localparam bit SAMPLE_RISE = sample_on_rise(CPOL, CPHA);

    logic [1:0] sclk_sync;
    logic [1:0] cs_sync;
    logic [1:0] mosi_sync;
    logic       sclk_prev;
    logic       cs_prev;
    logic       sclk_rise;
    logic       sclk_fall;

    // Synchronisers free-run through reset so the CS level is already valid on release.
    always_ff @(posedge clk) begin
        sclk_sync <= {sclk_sync[0], spi_clk};
        cs_sync   <= {cs_sync[0], spi_cs_n};
        mosi_sync <= {mosi_sync[0], spi_mosi};
        sclk_prev <= sclk_sync[1];
        cs_prev   <= cs_sync[1];
        cs_n_lvl  <= cs_sync[1];
        mosi_lvl  <= mosi_sync[1];
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sample_en <= 1'b0;
            shift_en  <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sample_en <= SAMPLE_RISE ? sclk_rise : sclk_fall;
            shift_en  <= SAMPLE_RISE ? sclk_fall : sclk_rise;
            cs_fall   <= ~cs_sync[1] & cs_prev;
            cs_rise   <= cs_sync[1] & ~cs_prev;
        end
    end

endmodule

// File: rtl/spi_burst_regif.sv
// SPI slave to register-bus bridge: R/W bit + address header, then bursts of
// data words with address auto-increment and prefetched reads.
module spi_burst_regif
    import spi_regif_pkg::*;
#(
    parameter int ADDR_W     = 7,
    parameter int DATA_W     = 8,
    parameter int CPOL       = 0,
    parameter int CPHA       = 0,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              spi_cs_n,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_abort
);

    localparam int              CNT_W     = $clog2(1 + ADDR_W + DATA_W);
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);

    logic sample_en, shift_en, cs_fall, cs_rise, cs_n_lvl, mosi_lvl;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      bit_cnt;
    logic [ADDR_W-1:0]     hdr_sh;
    logic [ADDR_W:0]       hdr_word;
    logic [DATA_W-2:0]     wsh;
    logic [DATA_W-1:0]     word_w;
    logic [ADDR_W-1:0]     addr_q;
    logic [RD_LATENCY-1:0] rd_pipe;
    logic [RD_LATENCY-1:0] rd_pipe_n;
    logic [DATA_W-1:0]     pf_data;
    logic [DATA_W-1:0]     tx_sh;
    logic                  miso_q;
    logic                  hdr_done, word_done, abort_d, in_frame;

    spi_edge_sync #(
        .CPOL(CPOL),
        .CPHA(CPHA)
    ) u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .spi_cs_n (spi_cs_n),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .sample_en(sample_en),
        .shift_en (shift_en),
        .cs_fall  (cs_fall),
        .cs_rise  (cs_rise),
        .cs_n_lvl (cs_n_lvl),
        .mosi_lvl (mosi_lvl)
    );

    assign hdr_word = {hdr_sh, mosi_lvl};
    assign word_w   = {wsh, mosi_lvl};
    assign in_frame = (state_q == ST_HDR) || (state_q == ST_WR_DATA) || (state_q == ST_RD_DATA);

    // CS edges are checked before SPI clock edges so a coincident CS edge wins.
    always_comb begin
        state_d   = state_q;
        hdr_done  = 1'b0;
        word_done = 1'b0;
        abort_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) state_d = ST_HDR;
            end
            ST_HDR: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sample_en && (bit_cnt == HDR_LAST)) begin
                    hdr_done = 1'b1;
                    state_d  = (hdr_word[ADDR_W] == RW_WRITE) ? ST_WR_DATA : ST_RD_DATA;
                end
            end
            ST_WR_DATA, ST_RD_DATA: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    abort_d = (bit_cnt != '0);
                end else if (sample_en && (bit_cnt == WORD_LAST)) begin
                    word_done = 1'b1;
                end
            end
            ST_WAIT_CS: begin
                if (cs_n_lvl) state_d = ST_IDLE;
            end
            default: state_d = ST_WAIT_CS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= ST_WAIT_CS;
        else          state_q <= state_d;
    end

    generate
        if (RD_LATENCY == 1) begin : g_pipe1
            assign rd_pipe_n = rd_stb;
        end else begin : g_pipen
            assign rd_pipe_n = {rd_pipe[RD_LATENCY-2:0], rd_stb};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            wr_stb      <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            rd_stb      <= 1'b0;
            rd_addr     <= '0;
            rd_pipe     <= '0;
            frame_abort <= 1'b0;
            miso_q      <= 1'b0;
        end else begin
            wr_stb      <= 1'b0;
            rd_stb      <= 1'b0;
            frame_abort <= abort_d;
            rd_pipe     <= rd_pipe_n;

            // Counter restarts per header and per word, so bursts never overflow it.
            if ((state_q == ST_IDLE) || hdr_done || word_done)
                bit_cnt <= '0;
            else if (sample_en && in_frame && !cs_rise)
                bit_cnt <= bit_cnt + CNT_W'(1);

            if (hdr_done && (hdr_word[ADDR_W] == RW_READ)) begin
                rd_stb  <= 1'b1;
                rd_addr <= hdr_word[ADDR_W-1:0];
            end
            if (word_done && (state_q == ST_WR_DATA)) begin
                wr_stb  <= 1'b1;
                wr_addr <= addr_q;
                wr_data <= word_w;
            end
            if (word_done && (state_q == ST_RD_DATA)) begin
                rd_stb  <= 1'b1;
                rd_addr <= addr_q + ADDR_W'(1);
            end

            if ((state_q != ST_RD_DATA) || (state_d != ST_RD_DATA))
                miso_q <= 1'b0;
            else if (shift_en)
                miso_q <= (bit_cnt == '0) ? pf_data[DATA_W-1] : tx_sh[DATA_W-1];
        end
    end

    // Datapath registers carry no reset; control above qualifies every use.
    always_ff @(posedge clk) begin
        if (sample_en) begin
            hdr_sh <= hdr_word[ADDR_W-1:0];
            wsh    <= word_w[DATA_W-2:0];
        end
        if (hdr_done)
            addr_q <= hdr_word[ADDR_W-1:0];
        else if (word_done)
            addr_q <= addr_q + ADDR_W'(1);
        if (rd_pipe[RD_LATENCY-1])
            pf_data <= rd_data;
        if (shift_en && (state_q == ST_RD_DATA))
            tx_sh <= (bit_cnt == '0) ? {pf_data[DATA_W-2:0], 1'b0} : {tx_sh[DATA_W-2:0], 1'b0};
    end

    assign busy        = in_frame && !cs_rise;
    assign spi_miso_oe = (state_q == ST_RD_DATA) && !cs_rise;
    assign spi_miso    = miso_q && spi_miso_oe;

endmodule

// File: tb/tb_spi_burst_regif.sv
// Bench for spi_burst_regif: three instances (mode 0, mode 3, mode 1 with read
// latency 3) driven by a bit-banged SPI master, with a strobe/MISO scoreboard.
module tb_spi_burst_regif;

    localparam int H     = 12;
    localparam int EV_WR = 0;
    localparam int EV_RD = 1;
    localparam int EV_AB = 2;

    typedef struct {
        int         k;
        int         kind;
        logic [6:0] addr;
        logic [7:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] miso_exp_q[$];
    logic [7:0] miso_got_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs_n [3];
    logic       sclk [3];
    logic       mosi [3];
    logic       miso [3];
    logic       oe [3];
    logic       wr_stb [3];
    logic       rd_stb [3];
    logic       busy [3];
    logic       abort [3];
    logic [6:0] wr_addr [3];
    logic [6:0] rd_addr [3];
    logic [7:0] wr_data [3];
    logic [7:0] rd_data [3];
    int         age [3] = '{0, 0, 0};
    logic [63:0] rx;

    always #5 clk = ~clk;

    spi_burst_regif #(.ADDR_W(7), .DATA_W(8), .CPOL(0), .CPHA(0), .RD_LATENCY(2)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .spi_cs_n(cs_n[0]), .spi_clk(sclk[0]), .spi_mosi(mosi[0]),
        .spi_miso(miso[0]), .spi_miso_oe(oe[0]), .wr_stb(wr_stb[0]), .wr_addr(wr_addr[0]),
        .wr_data(wr_data[0]), .rd_stb(rd_stb[0]), .rd_addr(rd_addr[0]), .rd_data(rd_data[0]),
        .busy(busy[0]), .frame_abort(abort[0]));

    spi_burst_regif #(.ADDR_W(7), .DATA_W(8), .CPOL(1), .CPHA(1), .RD_LATENCY(2)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .spi_cs_n(cs_n[1]), .spi_clk(sclk[1]), .spi_mosi(mosi[1]),
        .spi_miso(miso[1]), .spi_miso_oe(oe[1]), .wr_stb(wr_stb[1]), .wr_addr(wr_addr[1]),
        .wr_data(wr_data[1]), .rd_stb(rd_stb[1]), .rd_addr(rd_addr[1]), .rd_data(rd_data[1]),
        .busy(busy[1]), .frame_abort(abort[1]));

    spi_burst_regif #(.ADDR_W(7), .DATA_W(8), .CPOL(0), .CPHA(1), .RD_LATENCY(3)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .spi_cs_n(cs_n[2]), .spi_clk(sclk[2]), .spi_mosi(mosi[2]),
        .spi_miso(miso[2]), .spi_miso_oe(oe[2]), .wr_stb(wr_stb[2]), .wr_addr(wr_addr[2]),
        .wr_data(wr_data[2]), .rd_stb(rd_stb[2]), .rd_addr(rd_addr[2]), .rd_data(rd_data[2]),
        .busy(busy[2]), .frame_abort(abort[2]));

    // Register file model: data is only valid in the exact cycle RD_LATENCY after rd_stb.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rd_stb[k])                    age[k] <= 1;
            else if (age[k] != 0 && age[k] < 15) age[k] <= age[k] + 1;
        end
    end

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            rd_data[k] = 8'h00;
            if (age[k] == ((k == 2) ? 3 : 2)) rd_data[k] = {1'b0, rd_addr[k]} ^ 8'hFF;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic push_ev(input int k, input int kind, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        e.k = k; e.kind = kind; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic mon_ev(input int k, input int kind, input logic [6:0] a, input logic [7:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_event: dut%0d kind %0d addr %0h data %0h, none expected", k, kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.k != k || e.kind != kind || e.addr !== a || e.data !== d) begin
                n_bad++;
                $display("FAIL event: got dut%0d kind %0d addr %0h data %0h, want dut%0d kind %0d addr %0h data %0h",
                         k, kind, a, d, e.k, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (wr_stb[k] === 1'b1) mon_ev(k, EV_WR, wr_addr[k], wr_data[k]);
            if (rd_stb[k] === 1'b1) mon_ev(k, EV_RD, rd_addr[k], 8'h00);
            if (abort[k] === 1'b1)  mon_ev(k, EV_AB, 7'h00, 8'h00);
        end
        if (miso_got_q.size() != 0) begin
            logic [7:0] g, w;
            g = miso_got_q.pop_front();
            n_cmp++;
            if (miso_exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL miso_word: got %0h, none expected", g);
            end else begin
                w = miso_exp_q.pop_front();
                if (g !== w) begin
                    n_bad++;
                    $display("FAIL miso_word: got %0h, want %0h", g, w);
                end
            end
        end
    end

    task automatic spi_xfer(input int k, input int cpol, input int cpha, input int nbits,
                            input logic [63:0] vec, input bit hold_cs, output logic [63:0] rxv);
        rxv = '0;
        cs_n[k] = 1'b0;
        if (cpha == 0) mosi[k] = vec[nbits-1];
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            if (cpha == 0) begin
                sclk[k] = ~cpol[0];
                rxv = {rxv[62:0], miso[k]};
                wait_clk(H);
                sclk[k] = cpol[0];
                if (i + 1 < nbits) mosi[k] = vec[nbits-2-i];
                wait_clk(H);
            end else begin
                sclk[k] = ~cpol[0];
                mosi[k] = vec[nbits-1-i];
                wait_clk(H);
                sclk[k] = cpol[0];
                rxv = {rxv[62:0], miso[k]};
                wait_clk(H);
            end
        end
        if (!hold_cs) cs_n[k] = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            cs_n[k] = 1'b1;
            mosi[k] = 1'b0;
        end
        sclk[0] = 1'b0; sclk[1] = 1'b1; sclk[2] = 1'b0;
        reset_n = 1'b0;
        wait_clk(5);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_wr_stb%0d", k), wr_stb[k], 0);
            check($sformatf("rst_wr_addr%0d", k), wr_addr[k], 0);
            check($sformatf("rst_wr_data%0d", k), wr_data[k], 0);
            check($sformatf("rst_rd_stb%0d", k), rd_stb[k], 0);
            check($sformatf("rst_rd_addr%0d", k), rd_addr[k], 0);
            check($sformatf("rst_miso%0d", k), miso[k], 0);
            check($sformatf("rst_oe%0d", k), oe[k], 0);
            check($sformatf("rst_busy%0d", k), busy[k], 0);
            check($sformatf("rst_abort%0d", k), abort[k], 0);
        end
        reset_n = 1'b1;
        wait_clk(4);

        // Mode 0 single write
        push_ev(0, EV_WR, 7'h12, 8'hA5);
        spi_xfer(0, 0, 0, 16, {48'd0, 1'b0, 7'h12, 8'hA5}, 1'b0, rx);
        check("t1_busy_in_frame", busy[0], 1);
        wait_clk(2 * H);

        // Mode 3 write burst wrapping the address
        push_ev(1, EV_WR, 7'h7E, 8'h11);
        push_ev(1, EV_WR, 7'h7F, 8'h22);
        push_ev(1, EV_WR, 7'h00, 8'h33);
        spi_xfer(1, 1, 1, 32, {32'd0, 1'b0, 7'h7E, 8'h11, 8'h22, 8'h33}, 1'b0, rx);
        wait_clk(2 * H);

        // Mode 1 read burst with prefetch, latency 3
        push_ev(2, EV_RD, 7'h05, 8'h00);
        push_ev(2, EV_RD, 7'h06, 8'h00);
        push_ev(2, EV_RD, 7'h07, 8'h00);
        miso_exp_q.push_back(8'hFA);
        miso_exp_q.push_back(8'hF9);
        spi_xfer(2, 0, 1, 24, {40'd0, 1'b1, 7'h05, 16'h0000}, 1'b0, rx);
        check("t3_oe_in_read", oe[2], 1);
        miso_got_q.push_back(rx[15:8]);
        miso_got_q.push_back(rx[7:0]);
        wait_clk(3);
        check("t3_oe_after_cs", oe[2], 0);
        wait_clk(2 * H);

        // Write aborted after 4 data bits
        push_ev(0, EV_AB, 7'h00, 8'h00);
        spi_xfer(0, 0, 0, 12, {52'd0, 1'b0, 7'h33, 4'hA}, 1'b0, rx);
        check("t4_busy_before_drop", busy[0], 1);
        wait_clk(3);
        check("t4_busy_drop", busy[0], 0);
        wait_clk(2 * H);

        // Reset pulse in the middle of a read, CS held low
        push_ev(0, EV_RD, 7'h10, 8'h00);
        spi_xfer(0, 0, 0, 12, {52'd0, 1'b1, 7'h10, 4'h0}, 1'b1, rx);
        check("t5_oe_before_reset", oe[0], 1);
        reset_n = 1'b0;
        wait_clk(1);
        reset_n = 1'b1;
        wait_clk(1);
        check("t5_oe_after_reset", oe[0], 0);
        check("t5_busy_after_reset", busy[0], 0);
        check("t5_miso_after_reset", miso[0], 0);
        spi_xfer(0, 0, 0, 8, {56'd0, 8'hFF}, 1'b1, rx);
        check("t5_oe_cs_held", oe[0], 0);
        check("t5_busy_cs_held", busy[0], 0);
        cs_n[0] = 1'b1;
        wait_clk(2 * H);
        push_ev(0, EV_WR, 7'h01, 8'h3C);
        spi_xfer(0, 0, 0, 16, {48'd0, 1'b0, 7'h01, 8'h3C}, 1'b0, rx);
        wait_clk(2 * H);

        // Header-only read
        push_ev(0, EV_RD, 7'h20, 8'h00);
        spi_xfer(0, 0, 0, 8, {56'd0, 1'b1, 7'h20}, 1'b0, rx);
        check("t6_oe_before_drop", oe[0], 1);
        wait_clk(3);
        check("t6_oe_drop", oe[0], 0);
        check("t6_busy_drop", busy[0], 0);
        wait_clk(2 * H);

        check("events_left", exp_q.size(), 0);
        check("miso_exp_left", miso_exp_q.size(), 0);
        check("miso_got_left", miso_got_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_burst_regif.md
Name: spi_burst_regif

Overview:
- Parametrised SPI slave to register-bus bridge between the Raspberry Pi SPI master and the FPGA register file; next generation of the single-byte SPI register interface.
- Adds selectable SPI mode (CPOL/CPHA), configurable address/data widths, multi-word bursts with address auto-increment, and read prefetch with configurable latency.
- Adds an explicit MISO output enable and an abort flag for partial words.
- All logic runs on clk; SPI pins are treated as asynchronous.

Parameters:
- ADDR_W, 7: register address bits, excluding the R/W bit.
- DATA_W, 8: data word bits.
- CPOL, 0: SPI clock idle level.
- CPHA, 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- RD_LATENCY, 2: clk cycles from rd_stb until rd_data is valid, range 1..8.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset, synchronous, active-low; clock clk.
- spi_cs_n  in  1  chip select, active-low, async.
- spi_clk  in  1  SPI clock, async.
- spi_mosi  in  1  master data out, async.
- spi_miso  out  1  slave data.
- spi_miso_oe  out  1  MISO pad enable; pad tristated when 0.
- wr_stb  out  1  one-clk write strobe per complete write word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  DATA_W  write data.
- rd_stb  out  1  one-clk read request.
- rd_addr  out  ADDR_W  read address.
- rd_data  in  DATA_W  read data, valid RD_LATENCY clks after rd_stb.
- busy  out  1  frame in progress.
- frame_abort  out  1  one-clk pulse: CS deasserted mid-word.

Behaviour:
- Reset values: wr_stb=0, wr_addr=0, wr_data=0, rd_stb=0, rd_addr=0, spi_miso=0, spi_miso_oe=0, busy=0, frame_abort=0.
- Input conditioning: 2-FF synchroniser on spi_clk, spi_cs_n and spi_mosi, followed by an edge-detect register.
- Sample edge:
  - Rising spi_clk when CPOL==CPHA; falling otherwise.
  - The opposite edge is the shift-out edge.
  - Edge-enable latency is 3 clks after the pin transition.
- Frame format: bit0 = R/W (1 = read, 0 = write), then ADDR_W address bits MSB-first, then N≥0 words of DATA_W bits MSB-first.
- FSM states: IDLE, HDR, WR_DATA, RD_DATA, WAIT_CS.
  - IDLE → HDR on synchronised CS falling edge; busy=1.
  - HDR: counts 1+ADDR_W sample edges. On the last edge, latch the address, then go to WR_DATA or RD_DATA.
  - WR_DATA:
    - Each DATA_W samples forms a word.
    - Next clk: wr_stb=1, wr_data=word, wr_addr=current address.
    - Then address += 1, wrapping modulo 2^ADDR_W.
  - RD_DATA:
    - rd_stb=1 with rd_addr=address on the clk after the header completes.
    - After rd_stb, rd_data is captured after RD_LATENCY clks into the shift-out register.
    - spi_miso_oe=1 for the whole RD_DATA state.
    - The MSB is driven on the first shift-out edge after the header.
    - Each later shift-out edge presents the next bit.
    - On the sample edge of each word's last bit, address += 1 and the next rd_stb issues (prefetch).
  - Any state → IDLE on CS rising edge.
    - Clears busy and spi_miso_oe.
    - Pulses frame_abort if the data-phase bit count is not 0 modulo DATA_W.
    - A partial write word is discarded with no wr_stb.
    - A header-only frame produces no wr_stb and no abort.
- SPI timing requirement: SPI half-period ≥ RD_LATENCY+6 clks, so prefetched data is loaded before the shift-out edge. Faster clocks are unsupported; the behaviour is then undefined but must not hang the FSM.
- spi_miso holds its last value between shift edges and is 0 outside RD_DATA.
- Reset asserted mid-frame:
  - All outputs return to reset values.
  - FSM enters WAIT_CS and ignores all edges until CS is seen high, then goes to IDLE.
  - Applies likewise if reset is released while CS is low.
- CS edge and SPI clock edge in the same clk: the CS edge wins.
- The bit counter is sized $clog2(1+ADDR_W+DATA_W). Data-phase length is unbounded; the counter wraps per word.

Decomposition:
- Shared package spi_regif_pkg holds:
  - FSM state enum.
  - Constants RW_READ=1 and RW_WRITE=0.
  - Function sample_on_rise(CPOL,CPHA).
- Sub-module spi_edge_sync holds the synchronisers, edge detect, and the sample/shift enables.

Test Plan:
- Mode 0 write: addr 0x12, data 0xA5 → one wr_stb, wr_addr=0x12, wr_data=0xA5, no frame_abort.
- Mode 3 write burst: addr 0x7E, data 0x11,0x22,0x33 → wr_stb at 0x7E, 0x7F, 0x00 (wrap), data in order.
- Mode 1 read burst: addr 0x05, rd_data=addr^0xFF, RD_LATENCY=3 → MISO 0xFA then 0xF9; rd_stb at 0x05, 0x06, 0x07 (prefetch).
- Write aborted after 4 data bits → no wr_stb, one frame_abort pulse, busy=0 within 3 clks of CS high.
- reset_n low for 1 clk mid-read, CS stays low → spi_miso_oe=0, no strobes until CS high then low; the next frame (write 0x01=0x3C) is handled correctly.
- Header-only read frame, addr 0x20 → one rd_stb at 0x20, no frame_abort, spi_miso_oe drops with CS.
